multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 37 +++
 rtl/control_out_decode.sv | 98 +++++++++
 rtl/multicycle_control.sv | 99 +++++++++
 tb/tb_multicycle_control.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, ALU classes.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_t;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluRtype = 2'b10;

    function automatic logic op_is_legal(input logic [5:0] opcode);
        return (opcode == OpRtype) || (opcode == OpLw) || (opcode == OpSw) ||
               (opcode == OpBeq) || (opcode == OpBne) || (opcode == OpAddi) ||
               (opcode == OpJ);
    endfunction

endpackage

// File: rtl/control_out_decode.sv
// State -> control word decode for the multicycle controller (purely combinational).
module control_out_decode
    import multicycle_control_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opreg,
    input  logic [5:0] op,
    input  logic       memReady,
    input  logic       reset,
    output logic       pcWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic       memWrite,
    output logic       iorD,
    output logic       aluSrcA,
    output logic       regDst,
    output logic       memtoReg,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSrc,
    output logic [1:0] aluOp,
    output logic       branch,
    output logic       branchNe,
    output logic       illegalOp
);

    // Decode the control word for the current state; everything defaults to 0.
    always_comb begin
        pcWrite   = 1'b0;
        irWrite   = 1'b0;
        regWrite  = 1'b0;
        memWrite  = 1'b0;
        iorD      = 1'b0;
        aluSrcA   = 1'b0;
        regDst    = 1'b0;
        memtoReg  = 1'b0;
        aluSrcB   = 2'b00;
        pcSrc     = 2'b00;
        aluOp     = AluAdd;
        branch    = 1'b0;
        branchNe  = 1'b0;
        illegalOp = 1'b0;
        case (state)
            StFetch: begin
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
            end
            StDecode: begin
                aluSrcB = 2'b11;
                // op comes straight from the instruction register, stable this cycle
                illegalOp = !op_is_legal(op);
            end
            StMemAdr, StAddiEx: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            StMemRd: iorD = 1'b1;
            StMemWb: begin
                memtoReg = 1'b1;
                regWrite = 1'b1;
            end
            StMemWr: begin
                iorD     = 1'b1;
                memWrite = 1'b1;
            end
            StExecute: begin
                aluSrcA = 1'b1;
                aluOp   = AluRtype;
            end
            StAluWb: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
            end
            StBranch: begin
                aluSrcA  = 1'b1;
                aluOp    = AluSub;
                pcSrc    = 2'b01;
                branch   = (opreg == OpBeq);
                branchNe = (opreg == OpBne);
            end
            StAddiWb: regWrite = 1'b1;
            StJump: begin
                pcSrc   = 2'b10;
                pcWrite = 1'b1;
            end
            default: ;
        endcase
        // Reset masks every side effect, even before the state register clears.
        if (reset) begin
            pcWrite   = 1'b0;
            irWrite   = 1'b0;
            regWrite  = 1'b0;
            memWrite  = 1'b0;
            illegalOp = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main controller: state register, opcode latch, next-state logic.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic       memWrite,
    output logic       iorD,
    output logic       aluSrcA,
    output logic       regDst,
    output logic       memtoReg,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSrc,
    output logic [1:0] aluOp,
    output logic       branch,
    output logic       branchNe,
    output logic       illegalOp,
    output logic [3:0] state
);

    state_t     state_q, state_d;
    logic [5:0] opreg_q, opreg_d;

    // State and latched opcode registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            opreg_q <= 6'b000000;
        end else begin
            state_q <= state_d;
            opreg_q <= opreg_d;
        end
    end

    // Next-state selection and opcode capture in DECODE.
    always_comb begin
        state_d = state_q;
        opreg_d = opreg_q;
        case (state_q)
            StFetch:  state_d = memReady ? StDecode : StFetch;
            StDecode: begin
                opreg_d = op;
                case (op)
                    OpLw, OpSw:   state_d = StMemAdr;
                    OpRtype:      state_d = StExecute;
                    OpBeq, OpBne: state_d = StBranch;
                    OpAddi:       state_d = StAddiEx;
                    OpJ:          state_d = StJump;
                    default:      state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                if (opreg_q == OpLw) begin
                    state_d = StMemRd;
                end else if (opreg_q == OpSw) begin
                    state_d = StMemWr;
                end else begin
                    state_d = StFetch;
                end
            end
            StMemRd:   state_d = memReady ? StMemWb : StMemRd;
            StMemWr:   state_d = memReady ? StFetch : StMemWr;
            StExecute: state_d = StAluWb;
            StAddiEx:  state_d = StAddiWb;
            StMemWb, StAluWb, StBranch, StAddiWb, StJump: state_d = StFetch;
            default:   state_d = StFetch;
        endcase
    end

    assign state = state_q;

    control_out_decode u_decode (
        .state     (state_q),
        .opreg     (opreg_q),
        .op        (op),
        .memReady  (memReady),
        .reset     (reset),
        .pcWrite   (pcWrite),
        .irWrite   (irWrite),
        .regWrite  (regWrite),
        .memWrite  (memWrite),
        .iorD      (iorD),
        .aluSrcA   (aluSrcA),
        .regDst    (regDst),
        .memtoReg  (memtoReg),
        .aluSrcB   (aluSrcB),
        .pcSrc     (pcSrc),
        .aluOp     (aluOp),
        .branch    (branch),
        .branchNe  (branchNe),
        .illegalOp (illegalOp)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through the FSM.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       memReady;
    logic       pcWrite, irWrite, regWrite, memWrite;
    logic       iorD, aluSrcA, regDst, memtoReg;
    logic [1:0] aluSrcB, pcSrc, aluOp;
    logic       branch, branchNe, illegalOp;
    logic [3:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .memReady  (memReady),
        .pcWrite   (pcWrite),
        .irWrite   (irWrite),
        .regWrite  (regWrite),
        .memWrite  (memWrite),
        .iorD      (iorD),
        .aluSrcA   (aluSrcA),
        .regDst    (regDst),
        .memtoReg  (memtoReg),
        .aluSrcB   (aluSrcB),
        .pcSrc     (pcSrc),
        .aluOp     (aluOp),
        .branch    (branch),
        .branchNe  (branchNe),
        .illegalOp (illegalOp),
        .state     (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        op       = 6'b000000;
        memReady = 1'b1;
        step();
        step();
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_pcwrite", {31'd0, pcWrite}, 32'd0);
        chk("rst_irwrite", {31'd0, irWrite}, 32'd0);

        reset = 1'b0;
        #1;
        chk("fetch_irwrite", {31'd0, irWrite}, 32'd1);
        chk("fetch_pcwrite", {31'd0, pcWrite}, 32'd1);
        chk("fetch_alusrcb", {30'd0, aluSrcB}, 32'd1);

        // R-type: 0,1,6,7,0
        op = 6'b000000;
        step();
        chk("r_decode", {28'd0, state}, 32'd1);
        chk("r_decode_alusrcb", {30'd0, aluSrcB}, 32'd3);
        step();
        chk("r_execute", {28'd0, state}, 32'd6);
        chk("r_execute_aluop", {30'd0, aluOp}, 32'd2);
        chk("r_execute_alusrca", {31'd0, aluSrcA}, 32'd1);
        step();
        chk("r_aluwb", {28'd0, state}, 32'd7);
        chk("r_aluwb_regwrite", {31'd0, regWrite}, 32'd1);
        chk("r_aluwb_regdst", {31'd0, regDst}, 32'd1);
        step();
        chk("r_back_fetch", {28'd0, state}, 32'd0);

        // lw with two wait cycles in MEMRD
        op = 6'b100011;
        step();
        chk("lw_decode", {28'd0, state}, 32'd1);
        step();
        chk("lw_memadr", {28'd0, state}, 32'd2);
        chk("lw_memadr_alusrcb", {30'd0, aluSrcB}, 32'd2);
        step();
        memReady = 1'b0;
        #1;
        chk("lw_memrd1", {28'd0, state}, 32'd3);
        chk("lw_memrd_iord", {31'd0, iorD}, 32'd1);
        step();
        chk("lw_memrd2", {28'd0, state}, 32'd3);
        step();
        chk("lw_memrd3", {28'd0, state}, 32'd3);
        memReady = 1'b1;
        step();
        chk("lw_memwb", {28'd0, state}, 32'd4);
        chk("lw_memwb_memtoreg", {31'd0, memtoReg}, 32'd1);
        chk("lw_memwb_regwrite", {31'd0, regWrite}, 32'd1);
        step();
        chk("lw_back_fetch", {28'd0, state}, 32'd0);

        // bne
        op = 6'b000101;
        step();
        step();
        chk("bne_branch_state", {28'd0, state}, 32'd8);
        chk("bne_aluop", {30'd0, aluOp}, 32'd1);
        chk("bne_pcsrc", {30'd0, pcSrc}, 32'd1);
        chk("bne_branchne", {31'd0, branchNe}, 32'd1);
        chk("bne_branch", {31'd0, branch}, 32'd0);
        step();
        chk("bne_back_fetch", {28'd0, state}, 32'd0);

        // beq
        op = 6'b000100;
        step();
        step();
        chk("beq_branch_state", {28'd0, state}, 32'd8);
        chk("beq_branch", {31'd0, branch}, 32'd1);
        chk("beq_branchne", {31'd0, branchNe}, 32'd0);
        step();

        // illegal opcode
        op = 6'b111111;
        step();
        chk("ill_decode", {28'd0, state}, 32'd1);
        chk("ill_pulse", {31'd0, illegalOp}, 32'd1);
        chk("ill_enables", {28'd0, pcWrite, irWrite, regWrite, memWrite}, 32'd0);
        step();
        chk("ill_fetch", {28'd0, state}, 32'd0);
        chk("ill_pulse_end", {31'd0, illegalOp}, 32'd0);

        // addi
        op = 6'b001000;
        step();
        step();
        chk("addi_ex", {28'd0, state}, 32'd9);
        chk("addi_ex_alusrcb", {30'd0, aluSrcB}, 32'd2);
        step();
        chk("addi_wb", {28'd0, state}, 32'd10);
        chk("addi_wb_ctl", {29'd0, regWrite, regDst, memtoReg}, 32'd4);
        step();

        // sw interrupted by reset mid-wait
        op = 6'b101011;
        step();
        step();
        chk("sw_memadr", {28'd0, state}, 32'd2);
        step();
        memReady = 1'b0;
        #1;
        chk("sw_memwr", {28'd0, state}, 32'd5);
        chk("sw_memwrite", {31'd0, memWrite}, 32'd1);
        chk("sw_iord", {31'd0, iorD}, 32'd1);
        step();
        chk("sw_memwr_held", {28'd0, state}, 32'd5);
        chk("sw_memwrite_held", {31'd0, memWrite}, 32'd1);
        reset = 1'b1;
        #1;
        chk("sw_rst_memwrite", {31'd0, memWrite}, 32'd0);
        step();
        chk("sw_rst_state", {28'd0, state}, 32'd0);
        chk("sw_rst_memwrite2", {31'd0, memWrite}, 32'd0);
        reset    = 1'b0;
        memReady = 1'b1;

        // jump, then FETCH stalled on memReady
        op = 6'b000010;
        step();
        step();
        chk("j_state", {28'd0, state}, 32'd11);
        chk("j_pcsrc", {30'd0, pcSrc}, 32'd2);
        chk("j_pcwrite", {31'd0, pcWrite}, 32'd1);
        step();
        memReady = 1'b0;
        #1;
        chk("stall_fetch", {28'd0, state}, 32'd0);
        chk("stall_writes", {30'd0, irWrite, pcWrite}, 32'd0);
        step();
        chk("stall_held", {28'd0, state}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
